mem_bus_arbiter: RTL and testbench

//  Shares the single 8-bit memory port (address / data-in / write / data-out) between N_REQ bus masters,
//  e.g. the CPU and a DMA/port-copy engine. Round-robin with bounded ownership bursts.

---
 rtl/mem_bus_arbiter_pkg.sv | 18 +
 rtl/mem_bus_arbiter_rr_pick.sv | 32 +++
 rtl/mem_bus_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the memory bus arbiter.
// Used by mem_bus_arbiter and its round-robin picker.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    // Index width for a requester vector; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from start_i,
// wrapping modulo N_REQ. Returns one-hot, index and any-valid.
module mem_bus_arbiter_rr_pick
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        int unsigned j;
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        j        = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            j = (int'(start_i) + i) % N_REQ;
            if (!any_o && req_i[j]) begin
                any_o       = 1'b1;
                onehot_o[j] = 1'b1;
                idx_o       = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between N_REQ masters, with bounded bursts,
// a registered command stage and registered read return. Define MEM_ARB_LOCK_EN for the lock port.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        wr,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]       rdata,
    output logic [N_REQ-1:0]        rvalid,
    output logic [ADDR_W-1:0]       mem_address,
    output logic [DATA_W-1:0]       mem_data_in,
    output logic                    mem_write,
    input  logic [DATA_W-1:0]       mem_data_out
`ifdef MEM_ARB_LOCK_EN
    ,
    input  logic [N_REQ-1:0]        lock
`endif
);

    localparam int unsigned IDX_W  = idx_width(N_REQ);
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                mem_write_q;
    logic                rd_pend_q;
    logic [IDX_W-1:0]    rd_idx_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [N_REQ-1:0]    rvalid_q;

    logic [N_REQ-1:0]    gnt_c;
    logic [IDX_W-1:0]    gnt_idx_c;
    logic                accept_c;
    logic [IDX_W-1:0]    base_c;
    logic [IDX_W-1:0]    start_c;
    logic [N_REQ-1:0]    owner_mask_c;
    logic                others_c;
    logic                lock_c;
    logic [N_REQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;

    logic [ADDR_W-1:0]   addr_a  [N_REQ];
    logic [DATA_W-1:0]   wdata_a [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_a[g]  = addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = wdata[g*DATA_W +: DATA_W];
    end

`ifdef MEM_ARB_LOCK_EN
    assign lock_c = lock[owner_q];
`else
    assign lock_c = 1'b0;
`endif

    // Round-robin scan starts just past the previous owner (or the last owner when idle).
    assign base_c       = (state_q == ST_IDLE) ? last_q : owner_q;
    assign start_c      = (base_c == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(base_c + 1'b1);
    assign owner_mask_c = N_REQ'(1) << owner_q;
    assign others_c     = |(req & ~owner_mask_c);

    mem_bus_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i    (req),
        .start_i  (start_c),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        hold_d    = hold_q;
        gnt_c     = '0;
        gnt_idx_c = owner_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_c     = pick_onehot;
                    gnt_idx_c = pick_idx;
                    owner_d   = pick_idx;
                    hold_d    = HOLD_W'(1);
                    state_d   = ST_OWN;
                end
            end
            ST_OWN: begin
                if (req[owner_q] && ((hold_q < HOLD_W'(MAX_HOLD)) || !others_c || lock_c)) begin
                    gnt_c     = owner_mask_c;
                    gnt_idx_c = owner_q;
                    if (hold_q < HOLD_W'(MAX_HOLD)) begin
                        hold_d = HOLD_W'(hold_q + 1'b1);
                    end
                end else if (pick_any) begin
                    gnt_c     = pick_onehot;
                    gnt_idx_c = pick_idx;
                    owner_d   = pick_idx;
                    hold_d    = HOLD_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                    hold_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept_c = |gnt_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // Command stage toward memory, then read-data return one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_idx_q    <= '0;
            rdata_q     <= '0;
            rvalid_q    <= '0;
        end else begin
            if (accept_c) begin
                mem_addr_q  <= addr_a[gnt_idx_c];
                mem_wdata_q <= wdata_a[gnt_idx_c];
                mem_write_q <= wr[gnt_idx_c];
            end else begin
                mem_write_q <= 1'b0;
            end
            rd_pend_q <= accept_c & ~wr[gnt_idx_c];
            rd_idx_q  <= gnt_idx_c;
            rvalid_q  <= rd_pend_q ? (N_REQ'(1) << rd_idx_q) : '0;
            if (rd_pend_q) begin
                rdata_q <= mem_data_out;
            end
        end
    end

    // Grant is combinational; held off while reset is asserted.
    assign gnt         = reset ? '0 : gnt_c;
    assign rdata       = rdata_q;
    assign rvalid      = rvalid_q;
    assign mem_address = mem_addr_q;
    assign mem_data_in = mem_wdata_q;
    assign mem_write   = mem_write_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a behavioural 256x8 memory.
// Lock scenario is compiled only with MEM_ARB_LOCK_EN.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [7:0]  req_addr  [2];
    logic [7:0]  req_wdata [2];
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  gnt;
    logic [7:0]  rdata;
    logic [1:0]  rvalid;
    logic [7:0]  mem_address;
    logic [7:0]  mem_data_in;
    logic        mem_write;
    logic [7:0]  mem_data_out;
`ifdef MEM_ARB_LOCK_EN
    logic [1:0]  lock;
`endif

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    bit         mem_init_done;
    int         cyc;
    int         n_checks;
    int         n_fail;

    assign addr  = {req_addr[1], req_addr[0]};
    assign wdata = {req_wdata[1], req_wdata[0]};

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .wr           (wr),
        .addr         (addr),
        .wdata        (wdata),
        .gnt          (gnt),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out)
`ifdef MEM_ARB_LOCK_EN
        ,
        .lock         (lock)
`endif
    );

    function automatic logic [7:0] init_val(input int a);
        logic [7:0] v;
        v = 8'(a) ^ 8'h5A;
        if (a == 32'h20) v = 8'h5C;
        return v;
    endfunction

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_init_done <= 1'b1;
        end else if (mem_write) begin
            mem[mem_address] <= mem_data_in;
        end
    end
    assign mem_data_out = mem[mem_address];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Read-return monitor: every rvalid pulse must match the oldest expected read.
    always @(negedge clk) begin
        if (!reset) begin
            if (rvalid != 2'b00) begin
                if (sb.size() == 0) begin
                    check_eq("rv_spurious", 32'(rvalid), 32'h0);
                end else begin
                    check_eq("rv_idx",  32'(rvalid), 32'(2'b01 << sb[0].idx));
                    check_eq("rv_data", 32'(rdata),  32'(sb[0].data));
                    check_eq("rv_cyc",  32'(cyc),    32'(sb[0].cyc));
                    void'(sb.pop_front());
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                check_eq("rv_missing", 32'(cyc), 32'(sb[0].cyc - 1));
                void'(sb.pop_front());
            end
        end
    end

    // One bus cycle: check grant, log accepted commands, advance past the edge.
    task automatic step(input logic [1:0] exp_gnt, input string tag);
        @(negedge clk);
        check_eq(tag, 32'(gnt), 32'(exp_gnt));
        for (int i = 0; i < 2; i++) begin
            if (req[i] && gnt[i]) begin
                if (wr[i]) ref_mem[req_addr[i]] = req_wdata[i];
                else sb.push_back('{idx: i, data: ref_mem[req_addr[i]], cyc: cyc + 2});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
        wr[i]        = w;
        req_addr[i]  = a;
        req_wdata[i] = d;
    endtask

    initial begin
        logic [1:0] rr_seq [12];
        rr_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10,
                   2'b01, 2'b01, 2'b01, 2'b01};
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        reset = 1'b1;
        req   = 2'b11;
        wr    = 2'b00;
        drive(0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 8'h01, 8'h00);
`ifdef MEM_ARB_LOCK_EN
        lock = 2'b00;
`endif

        // Reset values while both masters request
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_gnt",    32'(gnt),         32'h0);
        check_eq("rst_rvalid", 32'(rvalid),      32'h0);
        check_eq("rst_rdata",  32'(rdata),       32'h0);
        check_eq("rst_addr",   32'(mem_address), 32'h0);
        check_eq("rst_din",    32'(mem_data_in), 32'h0);
        check_eq("rst_wr",     32'(mem_write),   32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: requester 0 wins first, then 1 after 0 drops
        step(2'b01, "t1_gnt0");
        req = 2'b10;
        step(2'b10, "t1_gnt1");
        req = 2'b00;
        repeat (2) step(2'b00, "t1_idle");

        // 2: write command reaches memory one edge after handshake
        drive(0, 1'b1, 8'h10, 8'hAB);
        req = 2'b01;
        step(2'b01, "t2_gnt");
        req = 2'b00;
        check_eq("t2_addr", 32'(mem_address), 32'h10);
        check_eq("t2_din",  32'(mem_data_in), 32'hAB);
        check_eq("t2_wr",   32'(mem_write),   32'h1);
        step(2'b00, "t2_idle");
        check_eq("t2_wr_off", 32'(mem_write),   32'h0);
        check_eq("t2_hold",   32'(mem_address), 32'h10);

        // 3: requester 1 read of 0x20
        drive(1, 1'b0, 8'h20, 8'h00);
        req = 2'b10;
        step(2'b10, "t3_gnt");
        req = 2'b00;
        repeat (3) step(2'b00, "t3_idle");

        // 4: bounded bursts under contention, then a lone requester never rotates
        drive(0, 1'b0, 8'h30, 8'h00);
        drive(1, 1'b0, 8'h31, 8'h00);
        req = 2'b11;
        for (int k = 0; k < 12; k++) step(rr_seq[k], "t4_rr");
        req = 2'b01;
        for (int k = 0; k < 10; k++) step(2'b01, "t4_lone");
        req = 2'b00;
        repeat (3) step(2'b00, "t4_idle");

        // 5: owner drops mid-burst, switch with no bubble; read sees the latest write
        drive(0, 1'b1, 8'h40, 8'h11);
        drive(1, 1'b0, 8'h40, 8'h00);
        req = 2'b01;
        step(2'b01, "t5_w1");
        req_wdata[0] = 8'h22;
        step(2'b01, "t5_w2");
        req_wdata[0] = 8'h33;
        req = 2'b11;
        step(2'b01, "t5_w3");
        check_eq("t5_wr_on", 32'(mem_write), 32'h1);
        req = 2'b10;
        step(2'b10, "t5_switch");
        check_eq("t5_rd_addr", 32'(mem_address), 32'h40);
        check_eq("t5_rd_nowr", 32'(mem_write),   32'h0);
        req = 2'b00;
        repeat (3) step(2'b00, "t5_idle");

`ifdef MEM_ARB_LOCK_EN
        // 6: lock holds the bus past MAX_HOLD; release lets requester 1 in
        drive(0, 1'b0, 8'h50, 8'h00);
        drive(1, 1'b0, 8'h51, 8'h00);
        req  = 2'b11;
        lock = 2'b11;
        for (int k = 0; k < 10; k++) step(2'b01, "t6_lock");
        lock = 2'b00;
        step(2'b10, "t6_unlock");
        req = 2'b00;
        repeat (3) step(2'b00, "t6_idle");
`endif

        // Reset during a read's return cycle: no rvalid ever
        drive(0, 1'b0, 8'h55, 8'h00);
        req = 2'b01;
        step(2'b01, "rr_gnt");
        req = 2'b00;
        void'(sb.pop_back());
        reset = 1'b1;
        @(negedge clk);
        check_eq("rr_rv_in_rst", 32'(rvalid), 32'h0);
        @(posedge clk);
        #1;
        check_eq("rr_rv_after", 32'(rvalid), 32'h0);
        reset = 1'b0;
        repeat (2) step(2'b00, "rr_idle");

        // Reset right after a write handshake drops the write
        drive(0, 1'b1, 8'h60, 8'h77);
        req = 2'b01;
        step(2'b01, "rw_gnt");
        req = 2'b00;
        wr  = 2'b00;
        check_eq("rw_wr_pre", 32'(mem_write), 32'h1);
        reset = 1'b1;
        #1;
        check_eq("rw_wr_drop", 32'(mem_write), 32'h0);
        ref_mem[8'h60] = init_val(32'h60);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) step(2'b00, "rw_idle");

        // Dropped write must not have reached memory
        drive(1, 1'b0, 8'h60, 8'h00);
        req = 2'b10;
        step(2'b10, "rw_chk_gnt");
        req = 2'b00;
        repeat (4) step(2'b00, "drain");
        check_eq("sb_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
